// File: rtl/elevator_pkg.sv
// Shared constants and types for the elevator direction scheduler slice.
package elevator_pkg;

  localparam logic [1:0] STOP   = 2'b00;
  localparam logic [1:0] UP     = 2'b10;
  localparam logic [1:0] DOWN   = 2'b01;
  localparam logic [1:0] UPDOWN = 2'b11;

  typedef logic [1:0] state_t;
  localparam state_t S_STOP = 2'd0;
  localparam state_t S_UP   = 2'd1;
  localparam state_t S_DOWN = 2'd2;
  localparam state_t S_REV  = 2'd3;

  localparam logic ON    = 1'b1;
  localparam logic OFF   = 1'b0;
  localparam logic MOVE  = 1'b1;
  localparam logic HOLD  = 1'b0;
  localparam logic OPEN  = 1'b1;
  localparam logic CLOSE = 1'b0;

  // Reversal is reported as STOP so the motion controller never sees a half-made decision.
  function automatic logic [1:0] state_dir(input state_t s);
    case (s)
      S_UP:    return UP;
      S_DOWN:  return DOWN;
      default: return STOP;
    endcase
  endfunction

endpackage

// File: rtl/elevator_direction_scheduler_call_register.sv
// One floor's up/down/car call latches; a button press in the service cycle wins over the clear.
module call_register
  import elevator_pkg::*;
#(
  parameter bit UP_EN = 1'b1,
  parameter bit DN_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       up_btn,
  input  logic       dn_btn,
  input  logic       car_btn,
  input  logic       service,
  input  logic [1:0] dir,
  output logic       up_call,
  output logic       dn_call,
  output logic       car_call
);

  logic up_q, up_d;
  logic dn_q, dn_d;
  logic car_q, car_d;

  always_comb begin
    up_d  = up_q;
    dn_d  = dn_q;
    car_d = car_q;
    if (service) begin
      car_d = OFF;
      if (dir != DOWN) up_d = OFF;
      if (dir != UP)   dn_d = OFF;
    end
    if (UP_EN && up_btn) up_d  = ON;
    if (DN_EN && dn_btn) dn_d  = ON;
    if (car_btn)         car_d = ON;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      up_q  <= OFF;
      dn_q  <= OFF;
      car_q <= OFF;
    end else begin
      up_q  <= up_d;
      dn_q  <= dn_d;
      car_q <= car_d;
    end
  end

  assign up_call  = up_q;
  assign dn_call  = dn_q;
  assign car_call = car_q;

endmodule

// File: rtl/elevator_direction_scheduler.sv
// Collective-selective (SCAN) direction controller with latched calls, delayed reversal
// and a sticky out-of-range floor fault.
module elevator_direction_scheduler
  import elevator_pkg::*;
#(
  parameter int FLOORS        = 7,
  parameter int FW            = $clog2(FLOORS + 1),
  parameter int REVERSE_DELAY = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [FW-1:0]       currentFloor,
  input  logic [2*FLOORS-1:0] floorButton,
  input  logic [FLOORS-1:0]   internalButton,
  input  logic                doorState,
  input  logic                move,
  output logic [1:0]          nextDirection,
  output logic [FLOORS-1:0]   callPending,
  output logic                stopHere,
  output logic                fault
);

  localparam int CW = (REVERSE_DELAY > 1) ? $clog2(REVERSE_DELAY + 1) : 1;

  logic [FLOORS-1:0] up_call, dn_call, car_call, pending;
  logic              in_range, service_en, fsm_en;
  logic              any_above, any_below, here_up, here_dn, here_car;

  state_t            state_q, state_d;
  logic [1:0]        dir_q, dir_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              orig_up_q, orig_up_d;
  logic              stop_q, stop_d;
  logic              fault_q, fault_d;

  assign in_range   = (currentFloor != '0) && (currentFloor <= FW'(FLOORS));
  assign service_en = in_range && (move == HOLD) && (doorState == OPEN);
  assign fsm_en     = in_range && (move == HOLD) && (doorState == CLOSE);

  for (genvar k = 1; k <= FLOORS; k++) begin : g_floor
    call_register #(
      .UP_EN(k < FLOORS),
      .DN_EN(k > 1)
    ) u_call (
      .clk     (clk),
      .reset   (reset),
      .up_btn  (floorButton[2*k-1]),
      .dn_btn  (floorButton[2*k-2]),
      .car_btn (internalButton[k-1]),
      .service (service_en && (currentFloor == FW'(k))),
      .dir     (dir_q),
      .up_call (up_call[k-1]),
      .dn_call (dn_call[k-1]),
      .car_call(car_call[k-1])
    );
  end

  assign pending = up_call | dn_call | car_call;

  always_comb begin
    any_above = 1'b0;
    any_below = 1'b0;
    here_up   = 1'b0;
    here_dn   = 1'b0;
    here_car  = 1'b0;
    for (int k = 1; k <= FLOORS; k++) begin
      if (FW'(k) > currentFloor) any_above = any_above | pending[k-1];
      if (FW'(k) < currentFloor) any_below = any_below | pending[k-1];
      if (FW'(k) == currentFloor) begin
        here_up  = up_call[k-1];
        here_dn  = dn_call[k-1];
        here_car = car_call[k-1];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    orig_up_d = orig_up_q;
    if (fsm_en) begin
      case (state_q)
        S_STOP: begin
          if (any_above)      state_d = S_UP;
          else if (any_below) state_d = S_DOWN;
        end
        S_UP: begin
          if (!any_above) begin
            if (!any_below) state_d = S_STOP;
            else if (REVERSE_DELAY == 0) state_d = S_DOWN;
            else begin
              state_d   = S_REV;
              cnt_d     = CW'(REVERSE_DELAY);
              orig_up_d = 1'b1;
            end
          end
        end
        S_DOWN: begin
          if (!any_below) begin
            if (!any_above) state_d = S_STOP;
            else if (REVERSE_DELAY == 0) state_d = S_UP;
            else begin
              state_d   = S_REV;
              cnt_d     = CW'(REVERSE_DELAY);
              orig_up_d = 1'b0;
            end
          end
        end
        default: begin
          // A fresh call in the original direction cancels the pending reversal.
          if (orig_up_q ? any_above : any_below) state_d = orig_up_q ? S_UP : S_DOWN;
          else if (cnt_q == '0)                  state_d = orig_up_q ? S_DOWN : S_UP;
          else if (!any_above && !any_below)     state_d = S_STOP;
          else                                   cnt_d   = cnt_q - CW'(1);
        end
      endcase
    end
    dir_d = state_dir(state_d);
  end

  always_comb begin
    stop_d = 1'b0;
    if (in_range) begin
      case (state_q)
        S_STOP:  stop_d = here_car | here_up | here_dn;
        S_UP:    stop_d = here_car | here_up | (here_dn & ~any_above);
        S_DOWN:  stop_d = here_car | here_dn | (here_up & ~any_below);
        default: stop_d = here_car;
      endcase
    end
    fault_d = fault_q | ~in_range;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_STOP;
      dir_q     <= STOP;
      cnt_q     <= '0;
      orig_up_q <= 1'b0;
      stop_q    <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      cnt_q     <= cnt_d;
      orig_up_q <= orig_up_d;
      stop_q    <= stop_d;
      fault_q   <= fault_d;
    end
  end

  assign nextDirection = dir_q;
  assign callPending   = pending;
  assign stopHere      = stop_q;
  assign fault         = fault_q;

endmodule
